// File: rtl/sw_cond_pkg.sv
// Shared definitions for the slide-switch conditioning block: debounce FSM
// state encoding and default timing constants for a 50 MHz system clock.
package sw_cond_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } sw_state_e;

    localparam int CLK_HZ                  = 50_000_000;
    localparam int DEBOUNCE_MS             = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/switch_debounce_chan.sv
// One switch channel: 2-FF synchroniser feeding a counter-based debounce FSM
// that owns the registered stable level and its rise/fall pulses.
module switch_debounce_chan
    import sw_cond_pkg::*;
#(
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw_i,
    output logic sw_stable_o,
    output logic sw_rise_o,
    output logic sw_fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             s2, mismatch;

    assign s2       = sync_q[1];
    assign mismatch = (s2 != stable_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], sw_raw_i};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // IDLE holds cnt at 0, so the same limit compare makes a 1-cycle debounce
    // accept on the very first mismatch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = s2;
                        rise_d   = s2;
                        fall_d   = ~s2;
                    end else begin
                        state_d = COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            COUNT: begin
                if (!mismatch) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = s2;
                    rise_d   = s2;
                    fall_d   = ~s2;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign sw_stable_o = stable_q;
    assign sw_rise_o   = rise_q;
    assign sw_fall_o   = fall_q;

endmodule

// File: rtl/switch_debounce_sync.sv
// Conditions raw slide-switch pins for the switches PIO: one synchronise +
// debounce channel per switch, with a combined change strobe.
module switch_debounce_sync
    import sw_cond_pkg::*;
#(
    parameter int N_SW            = 2,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_stable,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_change
);

    // The counter must reach DEBOUNCE_CYCLES-1 without wrapping.
    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_param
        $error("switch_debounce_sync: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_chan
        switch_debounce_chan #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .sw_raw_i    (sw_raw[i]),
            .sw_stable_o (sw_stable[i]),
            .sw_rise_o   (sw_rise[i]),
            .sw_fall_o   (sw_fall[i])
        );
    end

    assign sw_change = |{sw_rise, sw_fall};

endmodule
